// File: rtl/jtag_reg_bank_if.sv
// Debug register bus between the JTAG bridge (master) and a user register bank (slave).
// Writes are single-cycle strobes; reads are a flat bus the bridge slices by address.
interface jtag_reg_bank_if #(
  parameter int unsigned REG_RD_DATA_WIDTH = 96
) ();

  logic [7:0]                   reg_wr_addr;
  logic [15:0]                  reg_wr_data;
  logic                         reg_wr_en;
  logic [REG_RD_DATA_WIDTH-1:0] reg_rd_data;

  modport master (
    output reg_wr_addr,
    output reg_wr_data,
    output reg_wr_en,
    input  reg_rd_data
  );

  modport slave (
    input  reg_wr_addr,
    input  reg_wr_data,
    input  reg_wr_en,
    output reg_rd_data
  );

endinterface

// File: rtl/jtag_reg_bank.sv
// User-side JTAG register bank: pulse, control, sticky W1C status and write statistics.
// Register k is exposed combinationally on reg_rd_data[16k+15:16k].
module jtag_reg_bank #(
  parameter int unsigned CTRL_NUM  = 2,
  parameter int unsigned STAT_NUM  = 2,
  parameter logic [15:0] CTRL_INIT = 16'h0000
) (
  input  logic                    reg_clk,
  input  logic                    rst,
  jtag_reg_bank_if.slave          bus,
  output logic [16*CTRL_NUM-1:0]  ctrl_out,
  output logic [15:0]             ctrl_pulse,
  input  logic [16*STAT_NUM-1:0]  stat_in
);

  localparam int unsigned REG_NUM   = CTRL_NUM + STAT_NUM + 2;
  localparam int unsigned STAT_BASE = CTRL_NUM + 1;
  localparam int unsigned INFO_ADDR = REG_NUM - 1;

  logic [CTRL_NUM-1:0][15:0] ctrl_q, ctrl_d;
  logic [STAT_NUM-1:0][15:0] stat_meta_q, stat_sync_q;
  logic [STAT_NUM-1:0][15:0] stat_q, stat_d;
  logic [15:0]               pulse_q, pulse_d;
  logic [7:0]                wr_cnt_q, wr_cnt_d;
  logic [7:0]                bad_cnt_q, bad_cnt_d;

  logic [CTRL_NUM-1:0] ctrl_sel;
  logic [STAT_NUM-1:0] stat_sel;
  logic                pulse_sel;
  logic                info_sel;
  logic                bad_addr;
  logic [31:0]         addr_ext;

  assign addr_ext = 32'(bus.reg_wr_addr);

  // Address decode; every select is qualified by the write strobe.
  always_comb begin
    ctrl_sel  = '0;
    stat_sel  = '0;
    pulse_sel = bus.reg_wr_en && (addr_ext == 32'd0);
    info_sel  = bus.reg_wr_en && (addr_ext == INFO_ADDR);
    bad_addr  = addr_ext >= REG_NUM;
    for (int unsigned i = 0; i < CTRL_NUM; i++) begin
      ctrl_sel[i] = bus.reg_wr_en && (addr_ext == i + 32'd1);
    end
    for (int unsigned j = 0; j < STAT_NUM; j++) begin
      stat_sel[j] = bus.reg_wr_en && (addr_ext == STAT_BASE + j);
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    for (int unsigned i = 0; i < CTRL_NUM; i++) begin
      if (ctrl_sel[i]) begin
        ctrl_d[i] = bus.reg_wr_data;
      end
    end
  end

  // Set is OR-ed in after the clear so a simultaneous set wins.
  always_comb begin
    stat_d = stat_q;
    for (int unsigned j = 0; j < STAT_NUM; j++) begin
      stat_d[j] = (stat_q[j] & ~(stat_sel[j] ? bus.reg_wr_data : 16'h0000)) | stat_sync_q[j];
    end
  end

  always_comb begin
    pulse_d = pulse_sel ? bus.reg_wr_data : 16'h0000;
  end

  // A write to INFO clears the counters and is itself not counted.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    bad_cnt_d = bad_cnt_q;
    if (info_sel) begin
      wr_cnt_d  = 8'h00;
      bad_cnt_d = 8'h00;
    end else if (bus.reg_wr_en) begin
      wr_cnt_d = wr_cnt_q + 8'd1;
      if (bad_addr && (bad_cnt_q != 8'hFF)) begin
        bad_cnt_d = bad_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge reg_clk or posedge rst) begin
    if (rst) begin
      ctrl_q      <= {CTRL_NUM{CTRL_INIT}};
      stat_meta_q <= '0;
      stat_sync_q <= '0;
      stat_q      <= '0;
      pulse_q     <= '0;
      wr_cnt_q    <= '0;
      bad_cnt_q   <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      stat_meta_q <= stat_in;
      stat_sync_q <= stat_meta_q;
      stat_q      <= stat_d;
      pulse_q     <= pulse_d;
      wr_cnt_q    <= wr_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  assign ctrl_out    = ctrl_q;
  assign ctrl_pulse  = pulse_q;
  // Address 0 (PULSE) is write-only and reads as zero.
  assign bus.reg_rd_data = {bad_cnt_q, wr_cnt_q, stat_q, ctrl_q, 16'h0000};

endmodule
